// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: sequences one external FP32 adder to reduce groups of
// N_ACC input values into a single sum. The adder registers its operands
// when add_valid is high and returns add_out with add_valid_out one cycle
// later; each result becomes the accumulator operand of the next add.
//
// Optional build macro FP_ACC_ZERO_SKIP_EN: when defined, a +0/-0 input
// (other than the first of a group) is counted without issuing an add,
// taking one cycle instead of two.
module fp_accum_ctrl #(
  parameter int N_ACC = 9,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        add_valid,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_out,
  input  logic        add_valid_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_OUT    = 2'd2;

  localparam logic [CNT_W-1:0] N_ACC_C = CNT_W'(N_ACC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      acc_q, acc_d;
  // Set when a clear abandons an add that is still in flight; the next
  // add_valid_out is that stale result and must be swallowed.
  logic             discard_q, discard_d;

  logic             xfer;
  logic             first_elem;
  logic             skip_zero;
  logic             issue_add;
  logic             take_result;
  logic [CNT_W-1:0] count_inc;
  logic             reach_last;

  // Handshake decode: what happens to the input and adder result this cycle
  always_comb begin
    // A clear cycle accepts nothing so no value is silently consumed.
    in_ready    = (state_q == ST_ACCEPT) && !reset && !clear;
    xfer        = in_valid && in_ready;
    first_elem  = (count_q == '0);
    count_inc   = count_q + CNT_ONE;
    reach_last  = (count_inc == N_ACC_C);
`ifdef FP_ACC_ZERO_SKIP_EN
    // Adding a signed zero cannot change the sum, so it is only counted.
    skip_zero   = xfer && !first_elem && (in_data[30:0] == 31'd0);
`else
    skip_zero   = 1'b0;
`endif
    issue_add   = xfer && !first_elem && !skip_zero;
    take_result = (state_q == ST_WAIT) && add_valid_out && !discard_q &&
                  !clear && !reset;
  end

  // Adder issue port: operands are zero whenever no add is issued
  always_comb begin
    add_valid = issue_add;
    add_a     = 32'd0;
    add_b     = 32'd0;
    if (issue_add) begin
      add_a = acc_q;
      add_b = in_data;
    end
  end

  // Output port: the sum is only presented while the group is complete
  always_comb begin
    out_valid = (state_q == ST_OUT);
    out_data  = out_valid ? acc_q : 32'd0;
  end

  // Next-state, counter and accumulator update
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;

    case (state_q)
      ST_ACCEPT: begin
        if (xfer) begin
          if (first_elem) begin
            acc_d   = in_data;
            count_d = CNT_ONE;
            if (N_ACC == 1) begin
              state_d = ST_OUT;
            end
          end else if (skip_zero) begin
            count_d = count_inc;
            if (reach_last) begin
              state_d = ST_OUT;
            end
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // No timeout: the adder is trusted to answer every issue.
        if (take_result) begin
          acc_d   = add_out;
          count_d = count_inc;
          state_d = reach_last ? ST_OUT : ST_ACCEPT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          count_d = '0;
          state_d = ST_ACCEPT;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
        count_d = '0;
      end
    endcase

    // Abort keeps acc (it is reloaded by the next first element).
    if (clear) begin
      state_d = ST_ACCEPT;
      count_d = '0;
    end
  end

  // Stale-result tracking across a clear that interrupts WAIT
  always_comb begin
    discard_d = discard_q;
    if (add_valid_out) begin
      discard_d = 1'b0;
    end
    if (clear && (state_q == ST_WAIT) && !add_valid_out) begin
      discard_d = 1'b1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ACCEPT;
      count_q   <= '0;
      acc_q     <= 32'd0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Directed bench for fp_accum_ctrl: a 9-value instance driven by a
// behavioural 1-cycle FP32 adder, plus a 1-value instance.
module tb_fp_accum_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clear;

  logic        in_valid, in_ready9, add_valid9, add_valid_out9;
  logic        out_valid9, out_ready;
  logic [31:0] in_data, add_a9, add_b9, add_out9, out_data9;

  logic        in_valid1, in_ready1, add_valid1, out_valid1, out_ready1;
  logic [31:0] in_data1, add_a1, add_b1, out_data1;

  fp_accum_ctrl #(.N_ACC(9), .CNT_W(8)) dut9 (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready9), .in_data(in_data),
    .add_valid(add_valid9), .add_a(add_a9), .add_b(add_b9),
    .add_out(add_out9), .add_valid_out(add_valid_out9),
    .out_valid(out_valid9), .out_ready(out_ready), .out_data(out_data9)
  );

  fp_accum_ctrl #(.N_ACC(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .clear(1'b0),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .add_valid(add_valid1), .add_a(add_a1), .add_b(add_b1),
    .add_out(32'd0), .add_valid_out(1'b0),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
  );

  // FP32 <-> real via the double encoding (normal values and zero only)
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] b;
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = 11'(f[30:23]) + 11'd896;
    b = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    b = $realtobits(r);
    e = b[62:52] - 11'd896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Adder model: operands captured on add_valid, result one cycle later
  logic        adder_en, stray_vld;
  logic        adder_vld_q = 1'b0;
  logic [31:0] adder_res_q = 32'd0;
  always @(posedge clk) begin
    adder_vld_q <= add_valid9 & adder_en;
    if (add_valid9) adder_res_q <= r2f(f2r(add_a9) + f2r(add_b9));
  end
  assign add_valid_out9 = adder_vld_q | stray_vld;
  assign add_out9       = stray_vld ? 32'h4479C000 : adder_res_q;

  int pulses9 = 0;
  int pulses1 = 0;
  always @(posedge clk) begin
    if (add_valid9 === 1'b1) pulses9 <= pulses9 + 1;
    if (add_valid1 === 1'b1) pulses1 <= pulses1 + 1;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  typedef struct {
    string       name;
    logic [31:0] first;
    logic [31:0] mid;
    logic [31:0] last;
    int          stall;
    logic [31:0] exp_sum;
    int          exp_cyc;
    int          exp_pulses;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] grp[9];

`ifdef FP_ACC_ZERO_SKIP_EN
  localparam int ZCYC = 10;
  localparam int ZPUL = 1;
`else
  localparam int ZCYC = 17;
  localparam int ZPUL = 8;
`endif

  // Stream grp[] into dut9, check out_valid timing/data/add count; with
  // handshake=1 also hold out_ready low for 'stall' cycles then take it.
  task automatic run_group(input string name, input int stall, input int exp_cyc,
                           input logic [31:0] exp_sum, input int exp_pulses,
                           input bit handshake);
    int i, i0, k, p0;
    i = 0; i0 = -1; k = 0; p0 = pulses9;
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_data   = grp[0];
    out_ready = handshake && (stall == 0);
    while (1) begin
      @(negedge clk);
      if (out_valid9) break;
      if (i > 100) begin
        n_chk++;
        $display("FAIL %s_timeout: no out_valid after %0d cycles, required by cycle %0d",
                 name, i, exp_cyc);
        in_valid = 1'b0;
        return;
      end
      if (in_valid && in_ready9) begin
        if (i0 < 0) i0 = i;
        k++;
      end
      @(posedge clk); #1;
      in_valid = (k < 9);
      if (k < 9) in_data = grp[k];
      i++;
    end
    chk({name, "_cycle"}, 32'(i - i0), 32'(exp_cyc));
    chk({name, "_sum"}, out_data9, exp_sum);
    chk({name, "_adds"}, 32'(pulses9 - p0), 32'(exp_pulses));
    if (!handshake) return;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      chk({name, "_stall_data"}, out_data9, exp_sum);
      chk({name, "_stall_ready"}, {31'd0, in_ready9}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({name, "_next_ready"}, {31'd0, in_ready9}, 32'd1);
    chk({name, "_out_drop"}, {31'd0, out_valid9}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, i;
    reset = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = 32'd0; out_ready1 = 1'b1;
    adder_en = 1'b1; stray_vld = 1'b0;

    vecs[0] = '{"ones",   32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 32'h41100000, 17, 8};
    vecs[1] = '{"twos",   32'h40000000, 32'h40000000, 32'h40000000, 5, 32'h41900000, 17, 8};
    vecs[2] = '{"zmid",   32'h3F800000, 32'h00000000, 32'h3F800000, 0, 32'h40000000, ZCYC, ZPUL};
    vecs[3] = '{"halves", 32'h3F000000, 32'h3F800000, 32'h3F000000, 2, 32'h41000000, 17, 8};
    vecs[4] = '{"zfirst", 32'h00000000, 32'h80000000, 32'h40800000, 0, 32'h40800000, ZCYC, ZPUL};
    vecs[5] = '{"negone", 32'hBF800000, 32'h3F800000, 32'h3F800000, 1, 32'h40E00000, 17, 8};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready9}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid9}, 32'd0);
    chk("rst_add_valid", {31'd0, add_valid9}, 32'd0);
    chk("rst_out_data", out_data9, 32'd0);
    chk("rst_add_a", add_a9, 32'd0);
    chk("rst_add_b", add_b9, 32'd0);
    chk("rst_in_ready1", {31'd0, in_ready1}, 32'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready9}, 32'd1);

    // Table-driven groups
    for (int v = 0; v < 6; v++) begin
      grp[0] = vecs[v].first;
      for (int j = 1; j < 8; j++) grp[j] = vecs[v].mid;
      grp[8] = vecs[v].last;
      run_group(vecs[v].name, vecs[v].stall, vecs[v].exp_cyc,
                vecs[v].exp_sum, vecs[v].exp_pulses, 1'b1);
    end

    // Clear in WAIT after the 4th value, stale result arrives a cycle later
    for (int j = 0; j < 9; j++) grp[j] = 32'h3F800000;
    k = 0; i = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 32'h3F800000;
    while (k < 4 && i < 50) begin
      @(negedge clk);
      if (in_valid && in_ready9) begin
        k++;
        if (k == 4) adder_en = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = (k < 4);
      i++;
    end
    @(negedge clk);
    chk("clr_wait_ready", {31'd0, in_ready9}, 32'd0);
    chk("clr_wait_count", 32'(dut9.count_q), 32'd3);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; stray_vld = 1'b1;
    @(negedge clk);
    chk("clr_count", 32'(dut9.count_q), 32'd0);
    chk("clr_ready", {31'd0, in_ready9}, 32'd1);
    @(posedge clk); #1;
    stray_vld = 1'b0; adder_en = 1'b1;
    @(negedge clk);
    chk("clr_acc_kept", dut9.acc_q, 32'h40400000);
    chk("clr_count_after_stray", 32'(dut9.count_q), 32'd0);
    chk("clr_no_out", {31'd0, out_valid9}, 32'd0);
    run_group("after_clr", 0, 17, 32'h41100000, 8, 1'b1);

    // Stray result while idle in ACCEPT
    @(posedge clk); #1; stray_vld = 1'b1;
    @(posedge clk); #1; stray_vld = 1'b0;
    @(negedge clk);
    chk("idle_stray_acc", dut9.acc_q, 32'h41100000);
    chk("idle_stray_count", 32'(dut9.count_q), 32'd0);

    // Reset while presenting a sum
    run_group("rst_fill", 0, 17, 32'h41100000, 8, 1'b0);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_out_valid_mid", {31'd0, out_valid9}, 32'd0);
    chk("rst_in_ready_mid", {31'd0, in_ready9}, 32'd0);
    chk("rst_out_data_mid", out_data9, 32'd0);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_in_ready_after", {31'd0, in_ready9}, 32'd1);
    run_group("after_rst", 0, 17, 32'h41100000, 8, 1'b1);

    // Single-value groups
    k = pulses1;
    @(posedge clk); #1;
    in_valid1 = 1'b1; in_data1 = 32'hC0490FDB;
    @(negedge clk);
    chk("n1_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    chk("n1_out_valid", {31'd0, out_valid1}, 32'd1);
    chk("n1_out_data", out_data1, 32'hC0490FDB);
    chk("n1_no_add", 32'(pulses1 - k), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("n1_out_drop", {31'd0, out_valid1}, 32'd0);
    chk("n1_ready_again", {31'd0, in_ready1}, 32'd1);
    chk("n1_add_a_idle", add_a1 | add_b1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
